// File: rtl/restoring_divider_if.sv
// Handshake and operand/result bundle between the control unit and the
// restoring divider.
//   start        request pulse, operands sampled on the accepting edge
//   dividend     unsigned dividend
//   divisor      unsigned divisor
//   quotient     registered quotient of the last completed operation
//   remainder    registered remainder of the last completed operation
//   busy         division in progress
//   done         one-cycle completion pulse
//   div_by_zero  last completed operation had a zero divisor
// master: control unit side; slave: divider side.
interface restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction and one
// quotient bit per clock, MSB first. A zero divisor completes in one cycle
// with an all-ones quotient and the dividend as remainder.
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-low
//   bus  restoring_divider_if.slave (start/operands in, results/status out)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, one quotient bit per clock
// FIN   | done pulse cycle; start accepted here as in IDLE
module restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    restoring_divider_if.slave    bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   q_w;
    logic [WIDTH-1:0]   d_w;
    logic [WIDTH:0]     r_w;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               div_zero;
    logic               last_iter;

    logic [WIDTH+1:0]   rem_ext;
    logic [WIDTH+1:0]   trial;
    logic               trial_neg;
    logic [WIDTH:0]     r_next;
    logic [WIDTH-1:0]   q_next;

    assign accept    = bus.start && ((state == IDLE) || (state == FIN));
    assign div_zero  = (bus.divisor == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // One restoring step. The subtraction is one bit wider than the partial
    // remainder so its top bit is a clean borrow/sign flag.
    always_comb begin
        rem_ext   = {r_w, q_w[WIDTH-1]};
        trial     = rem_ext - {2'b00, d_w};
        trial_neg = trial[WIDTH+1];
        r_next    = trial_neg ? rem_ext[WIDTH:0] : trial[WIDTH:0];
        q_next    = {q_w[WIDTH-2:0], ~trial_neg};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = div_zero ? FIN : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                if (accept) begin
                    state_next = div_zero ? FIN : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_w             <= '0;
            d_w             <= '0;
            r_w             <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (accept) begin
            q_w <= bus.dividend;
            d_w <= bus.divisor;
            r_w <= '0;
            cnt <= '0;
            if (div_zero) begin
                bus.quotient    <= '1;
                bus.remainder   <= bus.dividend;
                bus.div_by_zero <= 1'b1;
            end else begin
                bus.div_by_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            q_w <= q_next;
            r_w <= r_next;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
                bus.quotient  <= q_next;
                bus.remainder <= r_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed testbench for restoring_divider: hand-computed vectors covering
// latency, corners, divide-by-zero, busy protection, back-to-back and reset.
module tb_restoring_divider;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] prev_q   = '0;
    logic [31:0] prev_r   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive operands for one edge, then scramble them so any late resampling
    // shows up in the result.
    task automatic start_op(input logic [31:0] dvd, input logic [31:0] dvs);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 32'h0000_0003;
    endtask

    task automatic run_op(input string tag,
                          input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dbz, input int exp_cyc, input int exp_busy,
                          input int inject_at, input bit settle);
        int cyc;
        int busy_n;
        bit hold_ok;
        start_op(dvd, dvs);
        cyc     = 0;
        busy_n  = 0;
        hold_ok = 1'b1;
        @(negedge clk);
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy === 1'b1) busy_n++;
            if (bus.quotient !== prev_q || bus.remainder !== prev_r) hold_ok = 1'b0;
            if (cyc == inject_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, " latency"},     32'(cyc),        32'(exp_cyc));
        check({tag, " busy_cycles"}, 32'(busy_n),     32'(exp_busy));
        check({tag, " quotient"},    bus.quotient,    exp_q);
        check({tag, " remainder"},   bus.remainder,   exp_r);
        check({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, {31'd0, exp_dbz});
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " hold"},        {31'd0, hold_ok}, 32'd1);
        prev_q = exp_q;
        prev_r = exp_r;
        if (settle) begin
            @(negedge clk);
            check({tag, " done_single"}, {31'd0, bus.done}, 32'd0);
        end
    endtask

    initial begin
        bit seen;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (3) @(negedge clk);
        check("rst quotient",    bus.quotient,  32'd0);
        check("rst remainder",   bus.remainder, 32'd0);
        check("rst busy",        {31'd0, bus.busy},        32'd0);
        check("rst done",        {31'd0, bus.done},        32'd0);
        check("rst div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32, -1, 1'b1);
        run_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 32, -1, 1'b1);
        run_op("3/10",  32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 32, 32, -1, 1'b1);
        run_op("msb/max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32, 32, -1, 1'b1);

        run_op("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0, -1, 1'b1);
        run_op("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32, 32, -1, 1'b1);

        run_op("ignore_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32, 10, 1'b1);

        run_op("b2b_first", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32, -1, 1'b0);
        run_op("b2b_second", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 32, 32, -1, 1'b1);

        start_op(32'd77, 32'd5);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst quotient",    bus.quotient,  32'd0);
        check("midrst remainder",   bus.remainder, 32'd0);
        check("midrst busy",        {31'd0, bus.busy},        32'd0);
        check("midrst done",        {31'd0, bus.done},        32'd0);
        check("midrst div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("midrst no_done", {31'd0, seen}, 32'd0);
        prev_q = '0;
        prev_r = '0;
        run_op("after_rst", 32'd12345, 32'd100, 32'd123, 32'd45, 1'b0, 32, 32, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
